result_capture: RTL
===================

RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in records (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 4, width of the saturating active-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 y  input  8  result bus from the upstream control/datapath stage.
REQ-006 s  input  3  step/status bus from the upstream stage.
REQ-007 b  input  1  flag bit from the upstream stage.
REQ-008 regime  input  2  upstream mode: 0 idle, 1 enumerate, 2 count, 3 update.
REQ-009 active  input  1  upstream active indication.
REQ-010 clr_ovf  input  1  one-cycle pulse that clears overflow and drop_cnt.
REQ-011 out_valid  output  1  head record available.
REQ-012 out_ready  input  1  consumer accepts the head record.
REQ-013 out_data  output  14+CNT_W  head record: {regime[1:0], y[7:0], s[2:0], b, act_cnt[CNT_W-1:0]}, MSB first.
REQ-014 overflow  output  1  sticky: a record was dropped.
REQ-015 drop_cnt  output  4  saturating count of dropped records.
REQ-016 level  output  $clog2(DEPTH)+1  records currently stored.

Function
REQ-017 Tracker FSM SHALL have two states, IDLE and RUN, plus registers op[1:0] and act_cnt.
REQ-018 IDLE, regime==0: SHALL remain in IDLE; no push.
REQ-019 IDLE, regime!=0: SHALL go to RUN, set op=regime, set act_cnt=active.
REQ-020 RUN, regime==op: SHALL stay in RUN; act_cnt += active, saturating at 2^CNT_W-1.
REQ-021 RUN, regime==0: SHALL push {op, y, s, b, act_cnt} using the current-cycle y/s/b, then go to IDLE.
REQ-022 RUN, regime!=0 and !=op: SHALL push the record as in REQ-021, set op=regime, set act_cnt=active, and stay in RUN.
REQ-023 A pushed record SHALL appear on out_valid/out_data on the cycle after the push edge (one-cycle latency), unless older records precede it.
REQ-024 Pop SHALL occur on an edge where out_valid && out_ready; out_data SHALL then present the next record, or out_valid SHALL drop when the FIFO is empty.
REQ-025 out_data SHALL be stable while out_valid && !out_ready.
REQ-026 Push when level==DEPTH with no same-cycle pop: the record SHALL be dropped, overflow set, and drop_cnt incremented (saturating at 15); stored records SHALL be unchanged.
REQ-027 Push and pop on the same edge when full: both SHALL succeed, level stays DEPTH, and nothing is dropped.
REQ-028 Push and pop on the same edge when empty is impossible; a push into an empty FIFO SHALL not be forwarded combinationally.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; level SHALL distinguish full from empty.
REQ-030 clr_ovf SHALL clear overflow and drop_cnt on the next edge; a drop on the same edge SHALL take priority (overflow=1, drop_cnt=1).
REQ-031 Inputs SHALL be sampled on the clock only; no combinational path from inputs to outputs other than out_ready to the FIFO read enable.

Reset
REQ-032 Asserted rst SHALL immediately force IDLE, op=0, act_cnt=0, an empty FIFO, out_valid=0, out_data=0, overflow=0, drop_cnt=0, level=0.
REQ-033 Reset mid-operation SHALL discard the in-progress record and all stored records; after release, a RUN SHALL start only on a fresh regime!=0 observed from IDLE.

Structure
REQ-034 Regime codes, record field offsets/widths, and FSM state encodings SHALL reside in a shared package/header, also used by the upstream controller.
REQ-035 Storage SHALL be a sub-module capture_fifo (DEPTH, width 14+CNT_W, push/pop/full/empty/level); the tracker FSM and overflow logic SHALL stay in result_capture.

Verification
REQ-036 Count op: regime=2 for 3 cycles with active=0, then 0, with y=8'h05, s=3, b=1 at end -> one record {2,05,3,1,0}, out_valid one cycle after the push.
REQ-037 Enumerate op: regime=1 for 6 cycles with active=1, then 0 -> act_cnt=6; with 20 active cycles (CNT_W=4) -> act_cnt=15.
REQ-038 Mode switch: regime 3 for 2 cycles, then 2 for 2 cycles, then 0 -> two records, op 3 then 2, each act_cnt reset.
REQ-039 Overflow: out_ready=0, 5 ops -> level=4, overflow=1, drop_cnt=1, head is the first op; clr_ovf -> overflow=0, drop_cnt=0.
REQ-040 Full with push and pop on the same edge, out_ready=1 -> no drop, level stays 4, records popped in order.
REQ-041 rst asserted asynchronously mid-RUN with 2 records stored -> all outputs 0 immediately; no record emitted after release.

Source files
------------

// File: rtl/result_capture_pkg.sv
// result_capture_pkg: regime codes, tracker states and record layout shared by
// result_capture and the upstream controller.
package result_capture_pkg;

    typedef enum logic [1:0] {
        RG_IDLE   = 2'd0,
        RG_ENUM   = 2'd1,
        RG_COUNT  = 2'd2,
        RG_UPDATE = 2'd3
    } regime_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } trk_state_e;

    localparam int OP_W = 2;
    localparam int Y_W = 8;
    localparam int S_W = 3;
    localparam int REC_HDR_W = OP_W + Y_W + S_W + 1;
    localparam int DROP_W = 4;

    // Field offsets above the act_cnt field, which always sits at bit 0.
    localparam int B_OFF = 0;
    localparam int S_OFF = 1;
    localparam int Y_OFF = S_OFF + S_W;
    localparam int OP_OFF = Y_OFF + Y_W;

    function automatic int rec_w(input int cnt_w);
        return REC_HDR_W + cnt_w;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: power-of-two circular record buffer; a push while full is
// accepted only when a pop frees the head slot on the same edge.
module capture_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic          w_wr_en;
    logic          w_rd_en;

    assign full = r_level == (AW+1)'(DEPTH);
    assign empty = r_level == '0;
    assign level = r_level;
    assign w_rd_en = pop && !empty;
    assign w_wr_en = push && (!full || w_rd_en);
    assign dout = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
            r_level <= '0;
        end else begin
            r_wr <= w_wr_en ? r_wr + 1'b1 : r_wr;
            r_rd <= w_rd_en ? r_rd + 1'b1 : r_rd;
            r_level <= r_level + (AW+1)'(w_wr_en) - (AW+1)'(w_rd_en);
        end
    end

endmodule

// File: rtl/result_capture.sv
// result_capture: tracks upstream regime runs, packs one record per finished
// run into capture_fifo and accounts for records dropped while full.
module result_capture
    import result_capture_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Y_W-1:0]                y,
    input  logic [S_W-1:0]                s,
    input  logic                          b,
    input  logic [OP_W-1:0]               regime,
    input  logic                          active,
    input  logic                          clr_ovf,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [REC_HDR_W+CNT_W-1:0]    out_data,
    output logic                          overflow,
    output logic [DROP_W-1:0]             drop_cnt,
    output logic [$clog2(DEPTH):0]        level
);
    localparam int W = rec_w(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    trk_state_e        r_state;
    trk_state_e        w_state_nxt;
    logic [OP_W-1:0]   r_op;
    logic [OP_W-1:0]   w_op_nxt;
    logic [CNT_W-1:0]  r_act_cnt;
    logic [CNT_W-1:0]  w_act_nxt;
    logic              w_push;
    logic [W-1:0]      w_rec;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op <= '0;
            r_act_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op <= w_op_nxt;
            r_act_cnt <= w_act_nxt;
        end
    end

    // A run ends when regime leaves op; the finished record uses this cycle's y/s/b.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt = r_op;
        w_act_nxt = r_act_cnt;
        w_push = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (regime != RG_IDLE) begin
                    w_state_nxt = ST_RUN;
                    w_op_nxt = regime;
                    w_act_nxt = CNT_W'(active);
                end
            end
            ST_RUN: begin
                if (regime == r_op) begin
                    w_act_nxt = (r_act_cnt == CNT_MAX) ? r_act_cnt : r_act_cnt + CNT_W'(active);
                end else begin
                    w_push = 1'b1;
                    w_op_nxt = regime;
                    w_act_nxt = CNT_W'(active);
                    w_state_nxt = (regime == RG_IDLE) ? ST_IDLE : ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_rec = {r_op, y, s, b, r_act_cnt};
    assign out_valid = !w_empty;
    assign w_pop = out_valid && out_ready;
    assign w_drop = w_push && w_full && !w_pop;

    capture_fifo #(
        .DEPTH(DEPTH),
        .W(W)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(w_push),
        .pop(w_pop),
        .din(w_rec),
        .dout(out_data),
        .full(w_full),
        .empty(w_empty),
        .level(level)
    );

    // A drop on the clearing edge wins, so the count restarts at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            r_drop_cnt <= clr_ovf ? DROP_W'(1) : (r_drop_cnt == DROP_MAX) ? r_drop_cnt : r_drop_cnt + 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign overflow = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule
